vc_pop_arbiter: RTL

Sequences draining of the VC0/VC1 virtual-channel FIFOs into the D0/D1 destination FIFOs of the PCIe transaction datapath. Picks one VC per cycle with weighted round-robin and pops its head word. Routes the word to D0 or D1 from a destination bit. Throttles against D-FIFO fill levels compared to thresholds latched during init, and reports the active/idle/error state of the datapath.

---
 rtl/vc_pop_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/vc_pop_arbiter.sv
// Weighted round-robin pop arbiter draining VC0/VC1 into D0/D1.
// Optional VC_ARB_STATS_EN adds saturating per-VC grant counters.
module vc_pop_arbiter #(
    parameter int DATA_W     = 6,
    parameter int CNT_W      = 3,
    parameter int WEIGHT_VC0 = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [CNT_W-1:0]  umbral_D0,
    input  logic [CNT_W-1:0]  umbral_D1,
    input  logic              vc0_empty,
    input  logic              vc1_empty,
    input  logic [DATA_W-1:0] vc0_data,
    input  logic [DATA_W-1:0] vc1_data,
    input  logic [CNT_W-1:0]  d0_count,
    input  logic [CNT_W-1:0]  d1_count,
    input  logic              fifo_error,
    output logic              vc0_pop,
    output logic              vc1_pop,
    output logic              d0_push,
    output logic              d1_push,
    output logic [DATA_W-1:0] data_out,
    output logic              active_out,
    output logic              idle_out,
`ifdef VC_ARB_STATS_EN
    output logic              error_out,
    output logic [7:0]        grant_cnt_vc0,
    output logic [7:0]        grant_cnt_vc1
`else
    output logic              error_out
`endif
);

    typedef enum logic [2:0] {
        S_RESET,
        S_INIT,
        S_IDLE,
        S_ACTIVE,
        S_ERROR
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   thr_d0;
    logic [CNT_W-1:0]   thr_d1;
    logic [2:0]         wrr_cnt;
    logic [CNT_W:0]     fill_d0;
    logic [CNT_W:0]     fill_d1;
    logic               blk_d0;
    logic               blk_d1;
    logic               elig0;
    logic               elig1;
    logic               grant0;
    logic               grant1;
    logic               pop_any;
    logic [DATA_W-1:0]  sel_word;

    // Destination fill including the word being pushed this cycle
    always_comb begin
        fill_d0 = {1'b0, d0_count} + (CNT_W+1)'(d0_push);
        fill_d1 = {1'b0, d1_count} + (CNT_W+1)'(d1_push);
        blk_d0  = fill_d0 >= {1'b0, thr_d0};
        blk_d1  = fill_d1 >= {1'b0, thr_d1};
        elig0   = !vc0_empty &&
                  (vc0_data[DATA_W-2] ? !blk_d1 : !blk_d0);
        elig1   = !vc1_empty &&
                  (vc1_data[DATA_W-2] ? !blk_d1 : !blk_d0);
        grant0  = elig0 && (!elig1 || (wrr_cnt < 3'(WEIGHT_VC0)));
        grant1  = elig1 && !grant0;
        vc0_pop = (state == S_ACTIVE) && grant0;
        vc1_pop = (state == S_ACTIVE) && grant1;
        pop_any = vc0_pop || vc1_pop;
        sel_word = vc1_pop ? vc1_data : vc0_data;
    end

    // Next-state decode; error wins over init except when leaving ERROR
    always_comb begin
        state_nx = state;
        case (state)
            S_RESET: begin
                if (init) state_nx = S_INIT;
            end
            S_INIT: begin
                if (fifo_error) state_nx = S_ERROR;
                else if (!init) state_nx = S_IDLE;
            end
            S_IDLE: begin
                if (fifo_error) state_nx = S_ERROR;
                else if (init) state_nx = S_INIT;
                else if (!vc0_empty || !vc1_empty) state_nx = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (fifo_error) state_nx = S_ERROR;
                else if (init) state_nx = S_INIT;
                else if (vc0_empty && vc1_empty && !d0_push && !d1_push)
                    state_nx = S_IDLE;
            end
            S_ERROR: begin
                if (init) state_nx = S_INIT;
            end
            default: state_nx = S_RESET;
        endcase
    end

    // State register and registered one-hot status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_RESET;
            active_out <= 1'b0;
            idle_out   <= 1'b0;
            error_out  <= 1'b0;
        end else begin
            state      <= state_nx;
            active_out <= state_nx == S_ACTIVE;
            idle_out   <= state_nx == S_IDLE;
            error_out  <= state_nx == S_ERROR;
        end
    end

    // Thresholds follow the umbral inputs only while configuring
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thr_d0 <= '0;
            thr_d1 <= '0;
        end else if (state == S_INIT) begin
            thr_d0 <= umbral_D0;
            thr_d1 <= umbral_D1;
        end
    end

    // VC0 run-length counter bounding consecutive VC0 grants
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrr_cnt <= '0;
        end else if (state == S_ACTIVE) begin
            if (vc0_pop && elig1) wrr_cnt <= wrr_cnt + 3'd1;
            else if (vc1_pop || !elig1) wrr_cnt <= '0;
        end
    end

    // Popped word lands in the D FIFO one cycle later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d0_push  <= 1'b0;
            d1_push  <= 1'b0;
            data_out <= '0;
        end else begin
            d0_push <= pop_any && !sel_word[DATA_W-2];
            d1_push <= pop_any && sel_word[DATA_W-2];
            if (pop_any) data_out <= sel_word;
        end
    end

`ifdef VC_ARB_STATS_EN
    logic enter_init;
    assign enter_init = (state_nx == S_INIT) && (state != S_INIT);

    // Saturating grant statistics, cleared on each new config phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_cnt_vc0 <= '0;
            grant_cnt_vc1 <= '0;
        end else if (enter_init) begin
            grant_cnt_vc0 <= '0;
            grant_cnt_vc1 <= '0;
        end else begin
            if (vc0_pop && grant_cnt_vc0 != 8'hFF)
                grant_cnt_vc0 <= grant_cnt_vc0 + 8'd1;
            if (vc1_pop && grant_cnt_vc1 != 8'hFF)
                grant_cnt_vc1 <= grant_cnt_vc1 + 8'd1;
        end
    end
`endif

endmodule
